mine_input_ctrl: RTL and testbench
==================================

// Module: mine_input_ctrl
// PURPOSE
//  Receive side of the board's five-button interface (right/left/up/down/middle).
//  Synchronises and debounces the raw pushbuttons and turns them into single-press events.
//  Moves a cursor over the GRID_W x GRID_H minefield and issues reveal requests to the
//  board-state memory over a req/ack handshake. Sits between the top-level pins and the
//  cell/number memories.
// PARAMETERS
//  GRID_W          5    columns in the board
//  GRID_H          5    rows in the board
//  ADDR_W          5    cell address width; must satisfy 2**ADDR_W >= GRID_W*GRID_H
//  DEBOUNCE_CYCLES 4    consecutive stable cycles needed to accept a level; 250000 in synthesis
// PORTS
//  clock        in   1       system clock; all flops on rising edge
//  reset        in   1       asynchronous, active-low
//  right,left   in   1 each  raw pushbuttons, asynchronous, active-high
//  up,down      in   1 each  raw pushbuttons, asynchronous, active-high
//  middle       in   1       raw pushbutton, asynchronous, active-high; reveal command
//  game_over    in   1       board lost or won; blocks new reveals
//  cursor_x     out  3       current column, 0..GRID_W-1
//  cursor_y     out  3       current row, 0..GRID_H-1
//  cursor_addr  out  ADDR_W  cursor_y*GRID_W + cursor_x, registered
//  rev_req      out  1       reveal request to board memory
//  rev_addr     out  ADDR_W  cell to reveal; held stable while rev_req=1
//  rev_ack      in   1       single-cycle acknowledge from board memory
//  busy         out  1       high while the FSM is not in IDLE
// BEHAVIOUR
//  Reset (reset=0, asynchronous) forces every output and internal flop to 0 and the FSM to IDLE.
//  This covers reset mid-handshake: rev_req drops without waiting for rev_ack.
//  Per button:
//  - 2-flop synchroniser, then debounce.
//  - Stable level flips only after the synced input has differed from it for DEBOUNCE_CYCLES
//    consecutive cycles; any glitch restarts the count.
//  - A 0->1 stable transition makes a 1-cycle press pulse.
//  - Latency: raw rising edge to press pulse is DEBOUNCE_CYCLES+3 clocks.
//  - Release produces no pulse. A held button produces exactly one pulse.
//  Cursor: updates the cycle after a press pulse.
//  - right: x+1, saturating at GRID_W-1. left: x-1, saturating at 0. No wrap-around.
//  - down: y+1, saturating at GRID_H-1. up: y-1, saturating at 0. Row 0 is the top row.
//  - right and left pulsing in the same cycle: x unchanged. up and down together: y unchanged.
//  - An x pulse and a y pulse in the same cycle both apply.
//  - cursor_addr follows cursor_x/cursor_y one cycle later.
//  - Move pulses arriving while busy=1 are dropped; the cursor is frozen while busy.
//  FSM states:
//  - IDLE: on a middle pulse with game_over=0, latch cursor_addr into rev_addr, go to REQ.
//    A middle pulse with game_over=1 is ignored.
//  - REQ: rev_req=1. When rev_ack=1, go to DONE. No timeout; waits indefinitely.
//  - DONE: rev_req=0 for one cycle, then IDLE. Guarantees a gap between back-to-back requests.
//  - busy = (state != IDLE).
//  - A middle pulse in REQ or DONE is dropped; no queueing.
//  - rev_ack seen in IDLE or DONE is ignored.
//  - game_over rising during REQ does not abort an in-flight request.
//  - A middle pulse and a move pulse in the same IDLE cycle: reveal latches the pre-move
//    address; the move still applies.
// STRUCTURE
//  Shared package mine_pkg:
//  - GRID_W, GRID_H, ADDR_W, and the FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
//  - Function cell_addr(x,y), reused by the board memory and the VGA renderer.
//  Sub-module btn_debounce (synchroniser + counter + edge detect, parameter DEBOUNCE_CYCLES):
//  - Instantiated 5x.
//  Top level holds the cursor registers and the request FSM.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. After reset, raw right=1 held for 20 cycles -> one pulse 7 clocks after the edge;
//     cursor_x 0->1; cursor_addr=1 on the following cycle.
//  2. right high for 3 cycles, low, high for 3 cycles (glitchy) -> no pulse; cursor_x stays 0.
//  3. Five separate right presses, then four down presses -> cursor=(4,4), cursor_addr=24.
//     A sixth right press -> x stays 4. Press left and right together -> x unchanged.
//  4. Cursor (2,1); press middle -> rev_req=1, rev_addr=7, busy=1. A right press during REQ is
//     dropped. rev_ack after 5 cycles -> rev_req=0 next cycle; busy=0 one cycle later; cursor=(2,1).
//  5. game_over=1, press middle -> rev_req stays 0 and busy stays 0.
//  6. reset pulsed low while rev_req=1 -> rev_req, busy, cursor_x, cursor_y and rev_addr are all 0
//     immediately, without a clock edge.

Source files
------------

// File: rtl/mine_pkg.sv
// mine_pkg: board geometry, request FSM encoding and cell addressing shared by
// the input controller, board memory and VGA renderer.
package mine_pkg;

    localparam int GRID_W = 5;
    localparam int GRID_H = 5;
    localparam int ADDR_W = 5;

    localparam logic [2:0] X_MAX = 3'(GRID_W - 1);
    localparam logic [2:0] Y_MAX = 3'(GRID_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [2:0] x, input logic [2:0] y);
        return ADDR_W'(int'(y) * GRID_W + int'(x));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and rising-edge press pulse
// for one raw pushbutton.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q, prev_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic          flip;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        flip     = (s2_q != stable_q) && (cnt_q == LAST);
        cnt_d    = (s2_q == stable_q || flip) ? '0 : cnt_q + CW'(1);
        stable_d = flip ? s2_q : stable_q;
        press_d  = stable_q & ~prev_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            s1_q     <= btn;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/mine_input_ctrl.sv
// mine_input_ctrl: debounced five-button cursor control with a reveal req/ack
// handshake towards the board-state memory.
module mine_input_ctrl
    import mine_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              right,
    input  logic              left,
    input  logic              up,
    input  logic              down,
    input  logic              middle,
    input  logic              game_over,
    output logic [2:0]        cursor_x,
    output logic [2:0]        cursor_y,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              rev_req,
    output logic [ADDR_W-1:0] rev_addr,
    input  logic              rev_ack,
    output logic              busy
);

    logic [4:0]        raw, pulse;
    logic              idle;
    logic [2:0]        x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d, raddr_q, raddr_d;
    state_e            state_q, state_d;

    assign raw = {middle, down, up, left, right};

    genvar b;
    generate
        for (b = 0; b < 5; b++) begin : g_btn
            btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
                .clock(clock),
                .reset(reset),
                .btn  (raw[b]),
                .press(pulse[b])
            );
        end
    endgenerate

    assign idle = (state_q == IDLE);

    always_comb begin
        x_d = (!idle || pulse[0] == pulse[1]) ? x_q :
              pulse[0] ? ((x_q == X_MAX) ? x_q : x_q + 3'd1) :
                         ((x_q == 3'd0) ? x_q : x_q - 3'd1);
        y_d = (!idle || pulse[3] == pulse[2]) ? y_q :
              pulse[3] ? ((y_q == Y_MAX) ? y_q : y_q + 3'd1) :
                         ((y_q == 3'd0) ? y_q : y_q - 3'd1);
        addr_d  = cell_addr(x_q, y_q);
        state_d = state_q;
        raddr_d = raddr_q;
        // addr_q still holds the pre-move address when a move pulse coincides
        case (state_q)
            IDLE: if (pulse[4] && !game_over) begin
                state_d = REQ;
                raddr_d = addr_q;
            end
            REQ:     state_d = rev_ack ? DONE : REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            raddr_q <= '0;
            state_q <= IDLE;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            raddr_q <= raddr_d;
            state_q <= state_d;
        end
    end

    assign cursor_x    = x_q;
    assign cursor_y    = y_q;
    assign cursor_addr = addr_q;
    assign rev_addr    = raddr_q;
    assign rev_req     = (state_q == REQ);
    assign busy        = !idle;

endmodule

// File: tb/tb_mine_input_ctrl.sv
// tb_mine_input_ctrl: scoreboard bench; a cursor/request model pushes expected
// snapshots as buttons are driven, popped once the debounced effect has settled.
module tb_mine_input_ctrl;
    import mine_pkg::*;

    logic clock = 0, reset = 0;
    logic right = 0, left = 0, up = 0, down = 0, middle = 0, game_over = 0, rev_ack = 0;
    logic [2:0] cursor_x, cursor_y;
    logic [ADDR_W-1:0] cursor_addr, rev_addr;
    logic rev_req, busy;

    int n_cmp = 0, n_bad = 0;
    int mx = 0, my = 0, m_req = 0, m_raddr = 0;

    typedef struct {
        string tag;
        int x, y, addr, req, raddr, busy;
    } snap_t;
    snap_t exp_q[$];

    always #5 clock = ~clock;

    mine_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .right(right), .left(left), .up(up), .down(down),
        .middle(middle), .game_over(game_over), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cursor_addr(cursor_addr), .rev_req(rev_req), .rev_addr(rev_addr),
        .rev_ack(rev_ack), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input logic [4:0] m);
        {middle, down, up, left, right} = m;
    endtask

    task automatic push_exp(input string tag);
        snap_t s;
        s = '{tag, mx, my, my * GRID_W + mx, m_req, m_raddr, m_req};
        exp_q.push_back(s);
    endtask

    task automatic check_snap();
        snap_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'(exp_q.size()), 1);
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, ".x"}, 32'(cursor_x), e.x);
        chk({e.tag, ".y"}, 32'(cursor_y), e.y);
        chk({e.tag, ".addr"}, 32'(cursor_addr), e.addr);
        chk({e.tag, ".req"}, 32'(rev_req), e.req);
        chk({e.tag, ".raddr"}, 32'(rev_addr), e.raddr);
        chk({e.tag, ".busy"}, 32'(busy), e.busy);
    endtask

    task automatic model_press(input logic [4:0] m);
        int was_busy;
        was_busy = m_req;
        if (m[4] && !game_over && !m_req) begin
            m_req   = 1;
            m_raddr = my * GRID_W + mx;
        end
        if (!was_busy) begin
            if (m[0] && !m[1]) mx = (mx < GRID_W - 1) ? mx + 1 : mx;
            if (m[1] && !m[0]) mx = (mx > 0) ? mx - 1 : mx;
            if (m[3] && !m[2]) my = (my < GRID_H - 1) ? my + 1 : my;
            if (m[2] && !m[3]) my = (my > 0) ? my - 1 : my;
        end
    endtask

    task automatic act(input string tag, input logic [4:0] m);
        model_press(m);
        push_exp(tag);
        drive(m);
        tick(12);
        drive(5'b0);
        tick(12);
        check_snap();
    endtask

    initial begin
        int n;
        tick(2);
        reset = 1;
        tick(1);
        push_exp("reset");
        check_snap();

        // press-to-move latency and registered address lag
        drive(5'b00001);
        n = 0;
        while (cursor_x == 0 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("latency", n, 8);
        chk("addr_lag0", 32'(cursor_addr), 0);
        @(posedge clock);
        #1;
        chk("addr_lag1", 32'(cursor_addr), 1);
        tick(18);
        drive(5'b0);
        tick(12);
        mx = 1;
        push_exp("held_once");
        check_snap();

        // glitchy press never reaches the stability threshold
        push_exp("glitch");
        drive(5'b00001); tick(3);
        drive(5'b00000); tick(1);
        drive(5'b00001); tick(3);
        drive(5'b00000); tick(12);
        check_snap();

        for (int i = 0; i < 5; i++) act($sformatf("right%0d", i), 5'b00001);
        for (int i = 0; i < 4; i++) act($sformatf("down%0d", i), 5'b01000);
        act("right_sat", 5'b00001);
        act("lr_both", 5'b00011);
        act("ud_both", 5'b01100);
        act("left_up", 5'b00110);
        act("left", 5'b00010);
        act("up0", 5'b00100);
        act("up1", 5'b00100);

        act("reveal", 5'b10000);
        act("move_busy", 5'b00001);
        tick(5);
        rev_ack = 1;
        tick(1);
        rev_ack = 0;
        chk("ack.req", 32'(rev_req), 0);
        chk("ack.busy", 32'(busy), 1);
        tick(1);
        chk("done.busy", 32'(busy), 0);
        m_req = 0;
        push_exp("after_ack");
        check_snap();

        rev_ack = 1;
        tick(1);
        rev_ack = 0;
        tick(2);
        push_exp("ack_idle");
        check_snap();

        game_over = 1;
        act("go_mid", 5'b10000);
        game_over = 0;

        act("mid_move", 5'b10001);
        game_over = 1;
        tick(3);
        push_exp("go_inflight");
        check_snap();
        game_over = 0;

        // asynchronous reset in the middle of an outstanding request
        #2;
        reset = 0;
        #1;
        chk("arst.req", 32'(rev_req), 0);
        chk("arst.busy", 32'(busy), 0);
        chk("arst.x", 32'(cursor_x), 0);
        chk("arst.y", 32'(cursor_y), 0);
        chk("arst.raddr", 32'(rev_addr), 0);
        tick(2);
        reset = 1;
        mx = 0; my = 0; m_req = 0; m_raddr = 0;
        tick(2);
        push_exp("post_reset");
        check_snap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
